f2_cmd_sched: RTL and testbench
===============================

# f2_cmd_sched

Command scheduler in front of the f2 GPU's 3-bit `instruction` bus. It turns four user request lines (previous, next, rotate, negative) and an optional auto-advance timer into one well-formed GPU command at a time. Each command is held for a fixed pulse, followed by a mandatory zero gap so the GPU re-arms its one-shot latch. While a previous/next slide animation is running, the scheduler holds off further commands. Sits between button synchronisers and the GPU in the top level.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles a nonzero instruction is driven (≥1).
- `GAP_CYCLES`, default 2: cycles of instruction = 0 after each pulse (≥1).
- `ANIM_CYCLES`, default 524288: wait after prev/next while the GPU animates (256 steps × 2048-cycle delay).
- `AUTO_PERIOD`, default 50000000: idle cycles before an auto "next".

Ports:
- `sysclk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: reset is synchronous and active-low.
- `btn_prev` in 1: level request; rising edge = one request.
- `btn_next` in 1: level request; rising edge = one request.
- `btn_rotate` in 1: level request; rising edge = one request.
- `btn_negative` in 1: level request; rising edge = one request.
- `auto_en` in 1: enable auto-advance (level).
- `instruction` out 3: GPU command: 0 none, 1 prev, 2 next, 3 rotate, 4 negative. Registered.
- `busy` out 1: high whenever the FSM is not IDLE. Registered.
- `pending` out 4: queued requests {negative, rotate, next, prev}. Registered.

## Operation
- Edge detect: `btn_q` registers each button. Edge = btn & ~btn_q. During reset `btn_q` loads the current button levels, so a button held through reset yields no request.
- Pending: an edge sets its `pending` bit. Further edges on a bit that is already set are absorbed (no counting). A bit clears only on the posedge where its command is granted.
- Prev/next cancel: if prev and next are both pending while the FSM is IDLE, both bits clear on that edge and nothing is issued.
- Grant priority, in IDLE only: negative > rotate > prev > next.
- FSM states:
  - IDLE → ISSUE on a grant. Loads the code, sets the hold counter to HOLD_CYCLES-1.
  - ISSUE: instruction = code. When the counter reaches 0 → GAP, counter = GAP_CYCLES-1.
  - GAP: instruction = 0. When the counter reaches 0 → ANIM if the code was 1 or 2, else → IDLE.
  - ANIM: instruction = 0, counter = ANIM_CYCLES-1 counting down to 0, then → IDLE. Edges arriving in ANIM still set pending bits. They are served after ANIM, because the GPU ignores instructions while animating.
- Counter widths are $clog2 of the largest parameter they hold. Counters use decrement-to-zero only, with no wrap.
- Auto-advance:
  - The timer counts only while IDLE, `auto_en` = 1, and `pending` = 0.
  - At AUTO_PERIOD-1 it sets `pending[next]` and clears itself.
  - Any grant, or `auto_en` = 0, clears the timer.
- Edge and grant in the same cycle: an edge on a bit being granted that cycle is lost (clear wins). Edges on other bits are kept.

## Timing
- Reset values: instruction = 0, busy = 0, pending = 0, FSM = IDLE, all counters = 0, auto timer = 0.
- A button first sampled high at posedge k sets `pending` after k.
- The grant occurs at k+1 if IDLE. `instruction` and `busy` become valid after k+1.
- `instruction` is nonzero for exactly HOLD_CYCLES cycles, then 0 for exactly GAP_CYCLES cycles.
- Rotate/negative: busy drops after HOLD_CYCLES+GAP_CYCLES cycles. The next grant can occur on the edge at which busy is 0.
- Prev/next: busy stays high for HOLD_CYCLES+GAP_CYCLES+ANIM_CYCLES cycles.
- Reset asserted mid-operation: all outputs return to reset values after the first posedge with rst_n = 0. No command is replayed after reset.

## Configuration
- `F2_SCHED_AUTO_EN` defined: the auto-advance timer is built as described.
- Not defined: no timer logic, `auto_en` is ignored, and only button edges create requests.

## Test plan
- Reset, then a single rotate edge → instruction = 3 for 4 cycles, then 0 for 2, busy = 1 for 6 cycles, pending = 0 afterwards.
- Next edge with ANIM_CYCLES = 16 → instruction = 2 for 4 cycles, then 0 for 2 + 16 cycles with busy = 1. A negative edge during ANIM → instruction = 4 starting the cycle after busy falls.
- Negative, rotate, and prev edges on the same cycle → issued in order 4, 3, 1, each separated by its gap and the prev animation wait. No lost requests.
- Prev and next edges on the same cycle in IDLE → pending clears, instruction stays 0, busy stays 0.
- With `F2_SCHED_AUTO_EN` defined, AUTO_PERIOD = 10, auto_en = 1, no buttons → instruction = 2 issued once per 10 idle cycles plus the command and animation time. Clearing auto_en stops it. A button held through reset → no request.
- rst_n low during ISSUE of code 1 → instruction = 0, busy = 0, pending = 0 after the next posedge. Nothing is issued after release until a new edge.

Source files
------------

// File: rtl/f2_cmd_sched.sv
// f2_cmd_sched -- command scheduler for the f2 GPU 3-bit instruction bus.
//
// Turns rising edges on four button request lines (plus an optional
// auto-advance timer) into single GPU commands. Each command is driven for
// HOLD_CYCLES, followed by GAP_CYCLES of zero. After prev/next, the scheduler
// waits ANIM_CYCLES while the GPU animates the slide change.
//
// Ports:
//   sysclk       in   clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   btn_prev     in   level request, rising edge = request (code 1)
//   btn_next     in   level request, rising edge = request (code 2)
//   btn_rotate   in   level request, rising edge = request (code 3)
//   btn_negative in   level request, rising edge = request (code 4)
//   auto_en      in   auto-advance enable (ignored unless F2_SCHED_AUTO_EN)
//   instruction  out  [2:0] registered GPU command, 0 = none
//   busy         out  registered, high while the FSM is not idle
//   pending      out  [3:0] registered queued requests {neg, rot, next, prev}
//
// Build option: define F2_SCHED_AUTO_EN to include the auto-advance timer.

module f2_cmd_sched #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ANIM_CYCLES = 524288,
    parameter int unsigned AUTO_PERIOD = 50000000
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       btn_prev,
    input  logic       btn_next,
    input  logic       btn_rotate,
    input  logic       btn_negative,
    input  logic       auto_en,
    output logic [2:0] instruction,
    output logic       busy,
    output logic [3:0] pending
);

    localparam int unsigned HG_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (HG_MAX > ANIM_CYCLES) ? HG_MAX : ANIM_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ANIM_LD = CNT_W'(ANIM_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_ANIM
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       code;
    logic [3:0]       btn;
    logic [3:0]       btn_q;
    logic [3:0]       edges;
    logic             grant;
    logic [2:0]       grant_code;
    logic [3:0]       clr_mask;
    logic             auto_req;
    logic [3:0]       pending_nxt;

    assign btn   = {btn_negative, btn_rotate, btn_next, btn_prev};
    assign edges = btn & ~btn_q;

    // Grant decode from the registered pending bits; only acts in IDLE.
    // A simultaneous prev+next request cancels both without issuing.
    always_comb begin
        grant      = 1'b0;
        grant_code = '0;
        clr_mask   = '0;
        if (state == S_IDLE) begin
            if (pending[0] && pending[1]) begin
                clr_mask = 4'b0011;
            end else if (pending[3]) begin
                grant      = 1'b1;
                grant_code = 3'd4;
                clr_mask   = 4'b1000;
            end else if (pending[2]) begin
                grant      = 1'b1;
                grant_code = 3'd3;
                clr_mask   = 4'b0100;
            end else if (pending[0]) begin
                grant      = 1'b1;
                grant_code = 3'd1;
                clr_mask   = 4'b0001;
            end else if (pending[1]) begin
                grant      = 1'b1;
                grant_code = 3'd2;
                clr_mask   = 4'b0010;
            end
        end
    end

    // Clear wins over a same-cycle edge on the granted bit.
    always_comb begin
        pending_nxt = (pending | edges | {2'b00, auto_req, 1'b0}) & ~clr_mask;
    end

`ifdef F2_SCHED_AUTO_EN
    localparam int unsigned        AUTO_W    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_W-1:0]  AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_run;

    assign auto_run = (state == S_IDLE) && auto_en && (pending == '0);
    assign auto_req = auto_run && (auto_cnt == AUTO_LAST);

    always_ff @(posedge sysclk) begin
        if (!rst_n || !auto_en || grant) begin
            auto_cnt <= '0;
        end else if (auto_run) begin
            auto_cnt <= auto_req ? '0 : auto_cnt + AUTO_W'(1);
        end
    end
`else
    logic unused_auto_en;
    assign unused_auto_en = auto_en;
    assign auto_req       = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            code        <= '0;
            instruction <= '0;
            busy        <= 1'b0;
            pending     <= '0;
            // Load current levels so a button held through reset is not an edge.
            btn_q       <= btn;
        end else begin
            btn_q   <= btn;
            pending <= pending_nxt;
            unique case (state)
                S_IDLE: begin
                    if (grant) begin
                        state       <= S_ISSUE;
                        code        <= grant_code;
                        cnt         <= HOLD_LD;
                        instruction <= grant_code;
                        busy        <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (cnt == '0) begin
                        state       <= S_GAP;
                        cnt         <= GAP_LD;
                        instruction <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        if (code == 3'd1 || code == 3'd2) begin
                            state <= S_ANIM;
                            cnt   <= ANIM_LD;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ANIM: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f2_cmd_sched.sv
// Testbench for f2_cmd_sched: timeline-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
// Honors F2_SCHED_AUTO_EN the same way as the design.

module tb_f2_cmd_sched;

    localparam int unsigned H  = 4;
    localparam int unsigned G  = 2;
    localparam int unsigned A  = 16;
    localparam int unsigned AP = 10;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       btn_prev, btn_next, btn_rotate, btn_negative, auto_en;
    logic [2:0] instruction;
    logic       busy;
    logic [3:0] pending;

    int checks   = 0;
    int failures = 0;

    f2_cmd_sched #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .ANIM_CYCLES(A),
        .AUTO_PERIOD(AP)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .btn_prev    (btn_prev),
        .btn_next    (btn_next),
        .btn_rotate  (btn_rotate),
        .btn_negative(btn_negative),
        .auto_en     (auto_en),
        .instruction (instruction),
        .busy        (busy),
        .pending     (pending)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (timeline arithmetic) ----------------
    // A grant at edge g with code c owns instruction for edges [g, g+H),
    // busy for [g, g+H+G(+A)), and the scheduler is idle again from the
    // edge g+H+G(+A)+1 onward.
    longint     e = 0;
    longint     m_g = 0;
    longint     m_idle_from = 0;
    bit         m_gv = 0;
    int         m_code = 0;
    logic [3:0] m_p = '0;
    logic [3:0] m_bq = '0;
    int         m_timer = 0;
    int         m_instr = 0;
    int         m_busy = 0;

    always @(posedge sysclk) begin
        logic [3:0] b, ed, clr;
        bit         idle, granted, req;
        b = {btn_negative, btn_rotate, btn_next, btn_prev};
        e++;
        if (!rst_n) begin
            m_p = '0; m_bq = b; m_timer = 0; m_gv = 0; m_idle_from = e + 1;
        end else begin
            ed = b & ~m_bq;
            m_bq = b;
            idle = (e >= m_idle_from);
            clr = '0; granted = 0; req = 0;
            if (idle && m_p[0] && m_p[1]) begin
                clr = 4'b0011;
            end else if (idle && m_p != '0) begin
                if (m_p[3])      begin m_code = 4; clr = 4'b1000; end
                else if (m_p[2]) begin m_code = 3; clr = 4'b0100; end
                else if (m_p[0]) begin m_code = 1; clr = 4'b0001; end
                else             begin m_code = 2; clr = 4'b0010; end
                granted = 1; m_gv = 1; m_g = e;
                m_idle_from = e + H + G + ((m_code <= 2) ? A : 0) + 1;
            end
`ifdef F2_SCHED_AUTO_EN
            if (!auto_en || granted) m_timer = 0;
            else if (idle && m_p == '0) begin
                if (m_timer == AP - 1) begin req = 1; m_timer = 0; end
                else m_timer++;
            end
`endif
            m_p = (m_p | ed | (req ? 4'b0010 : 4'b0000)) & ~clr;
        end
        m_instr = (m_gv && e >= m_g && e < m_g + H) ? m_code : 0;
        m_busy  = (m_gv && e >= m_g && e < m_idle_from - 1) ? 1 : 0;
        #1;
        chk("model_instruction", int'(instruction), m_instr);
        chk("model_busy", int'(busy), m_busy);
        chk("model_pending", int'(pending), int'(m_p));
    end

    // ---------------- directed + random stimulus ----------------
    int starts[$];
    int start_t[$];

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Records the code and cycle index of every 0 -> nonzero transition.
    task automatic collect(input int n);
        int prev_i;
        starts.delete();
        start_t.delete();
        prev_i = int'(instruction);
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (instruction != 3'd0 && prev_i == 0) begin
                starts.push_back(int'(instruction));
                start_t.push_back(i);
            end
            prev_i = int'(instruction);
        end
    endtask

    initial begin
        rst_n = 1'b0; btn_prev = 1'b0; btn_next = 1'b0;
        btn_rotate = 1'b0; btn_negative = 1'b0; auto_en = 1'b0;
        cyc(3);
        chk("reset_instruction", int'(instruction), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pending", int'(pending), 0);
        rst_n = 1'b1;
        cyc(2);

        // Single rotate: 3 for 4 cycles, 0 for 2, busy 6 cycles.
        btn_rotate = 1'b1;
        cyc(1);
        chk("rot_pending_set", int'(pending), 4);
        btn_rotate = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("rot_instruction", int'(instruction), (i < 4) ? 3 : 0);
            chk("rot_busy", int'(busy), (i < 6) ? 1 : 0);
        end
        chk("rot_pending_clear", int'(pending), 0);
        cyc(2);

        // Next with animation wait; negative pressed during ANIM.
        btn_next = 1'b1;
        cyc(1);
        btn_next = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cyc(1);
            chk("next_instruction", int'(instruction), (i < 4) ? 2 : ((i == 23) ? 4 : 0));
            chk("next_busy", int'(busy), (i < 22 || i == 23) ? 1 : 0);
            if (i == 10) btn_negative = 1'b1;
            if (i == 11) btn_negative = 1'b0;
        end
        cyc(10);

        // Negative, rotate, prev together: served 4, 3, 1.
        btn_negative = 1'b1; btn_rotate = 1'b1; btn_prev = 1'b1;
        cyc(1);
        btn_negative = 1'b0; btn_rotate = 1'b0; btn_prev = 1'b0;
        collect(60);
        chk("triple_count", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("triple_first", starts[0], 4);
            chk("triple_second", starts[1], 3);
            chk("triple_third", starts[2], 1);
            chk("triple_spacing", start_t[1] - start_t[0], H + G + 1);
        end
        chk("triple_pending", int'(pending), 0);

        // Prev and next together cancel.
        btn_prev = 1'b1; btn_next = 1'b1;
        cyc(1);
        chk("cancel_pending_set", int'(pending), 3);
        btn_prev = 1'b0; btn_next = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("cancel_instruction", int'(instruction), 0);
            chk("cancel_busy", int'(busy), 0);
            chk("cancel_pending", int'(pending), 0);
        end

        // Reset during ISSUE of prev; rotate held through reset.
        btn_prev = 1'b1;
        cyc(1);
        btn_prev = 1'b0;
        cyc(2);
        chk("prev_issuing", int'(instruction), 1);
        rst_n = 1'b0; btn_rotate = 1'b1;
        cyc(1);
        chk("midrst_instruction", int'(instruction), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pending", int'(pending), 0);
        cyc(1);
        rst_n = 1'b1;
        collect(30);
        chk("post_rst_no_issue", starts.size(), 0);
        chk("post_rst_pending", int'(pending), 0);
        btn_rotate = 1'b0;
        cyc(2);

`ifdef F2_SCHED_AUTO_EN
        auto_en = 1'b1;
        collect(100);
        chk("auto_count", starts.size(), 3);
        if (starts.size() >= 2) begin
            chk("auto_code", starts[0], 2);
            chk("auto_first_t", start_t[0], AP);
            chk("auto_period", start_t[1] - start_t[0], AP + H + G + A + 1);
        end
        auto_en = 1'b0;
        cyc(40);
        collect(50);
        chk("auto_stopped", starts.size(), 0);
`else
        auto_en = 1'b1;
        collect(60);
        chk("auto_ignored", starts.size(), 0);
        auto_en = 1'b0;
`endif

        // Randomized traffic, checked every cycle by the model.
        for (int unsigned n = 0; n < 3000; n++) begin
            cyc(1);
            rst_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 5) == 0) btn_prev     = ~btn_prev;
            if ($urandom_range(0, 5) == 0) btn_next     = ~btn_next;
            if ($urandom_range(0, 7) == 0) btn_rotate   = ~btn_rotate;
            if ($urandom_range(0, 7) == 0) btn_negative = ~btn_negative;
            if ($urandom_range(0, 63) == 0) auto_en     = ~auto_en;
        end
        rst_n = 1'b1;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
